// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect owner: arbitrates IF/ID/MEM redirects into one Alt_PC,
// drives per-stage flushes, and sequences the syscall drain/resume.
module fetch_redirect_ctrl #(
  parameter int N_FE_STAGES  = 7,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   PRED_REQ,
  input  logic [31:0]            PRED_PC,
  input  logic                   ID_REQ,
  input  logic [31:0]            ID_PC,
  input  logic                   MEM_REQ,
  input  logic [31:0]            MEM_PC,
  input  logic                   SYS_REQ,
  input  logic [31:0]            SYS_PC,
  input  logic                   SYS_ACK,
  input  logic                   STALL,
  output logic                   ALT_PC_VALID,
  output logic [31:0]            ALT_PC,
  output logic [N_FE_STAGES-1:0] FLUSH_FE,
  output logic                   FLUSH_ID,
  output logic                   HOLD_FETCH,
  output logic                   SYS,
  output logic                   BUSY
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REDIR   = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] SYSWAIT = 2'd3;

  localparam logic [1:0] PRI_PRED = 2'd0;
  localparam logic [1:0] PRI_SYS  = 2'd1;
  localparam logic [1:0] PRI_ID   = 2'd2;
  localparam logic [1:0] PRI_MEM  = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  logic [1:0]             state;
  logic [1:0]             pend_pri;
  logic [3:0]             cnt;
  logic [31:0]            sys_pc;

  logic                   win_vld;
  logic [1:0]             win_pri;
  logic [31:0]            win_pc;
  logic [N_FE_STAGES-1:0] win_fe;
  logic                   win_id;
  logic                   win_redir;

  // Oldest instruction wins; losers are simply dropped.
  always_comb begin
    win_vld = 1'b0;
    win_pri = PRI_PRED;
    win_pc  = PRED_PC;
    win_fe  = '0;
    win_id  = 1'b0;
    priority case (1'b1)
      MEM_REQ: begin
        win_vld = 1'b1;
        win_pri = PRI_MEM;
        win_pc  = MEM_PC;
        win_fe  = '1;
        win_id  = 1'b1;
      end
      ID_REQ: begin
        win_vld = 1'b1;
        win_pri = PRI_ID;
        win_pc  = ID_PC;
        win_fe  = '1;
      end
      SYS_REQ: begin
        win_vld = 1'b1;
        win_pri = PRI_SYS;
        win_pc  = SYS_PC;
      end
      PRED_REQ: begin
        win_vld = 1'b1;
        win_pri = PRI_PRED;
        win_pc  = PRED_PC;
      end
      default: ;
    endcase
  end

  assign win_redir = win_vld && (win_pri != PRI_SYS);
  assign BUSY      = (state != IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      pend_pri     <= PRI_PRED;
      cnt          <= '0;
      sys_pc       <= '0;
      ALT_PC_VALID <= 1'b0;
      ALT_PC       <= '0;
      FLUSH_FE     <= '0;
      FLUSH_ID     <= 1'b0;
      HOLD_FETCH   <= 1'b0;
      SYS          <= 1'b0;
    end else begin
      FLUSH_FE <= '0;
      FLUSH_ID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld && (win_pri == PRI_SYS)) begin
            state      <= DRAIN;
            sys_pc     <= SYS_PC;
            FLUSH_FE   <= '1;
            cnt        <= CNT_INIT;
            HOLD_FETCH <= 1'b1;
          end else if (win_redir) begin
            state        <= REDIR;
            ALT_PC_VALID <= 1'b1;
            ALT_PC       <= win_pc;
            pend_pri     <= win_pri;
            FLUSH_FE     <= win_fe;
            FLUSH_ID     <= win_id;
          end
        end
        REDIR: begin
          // Only a strictly older request may replace the pending one.
          if (win_redir && (win_pri > pend_pri)) begin
            ALT_PC   <= win_pc;
            pend_pri <= win_pri;
            FLUSH_FE <= win_fe;
            FLUSH_ID <= win_id;
          end else if (!STALL) begin
            state        <= IDLE;
            ALT_PC_VALID <= 1'b0;
            ALT_PC       <= '0;
          end
        end
        DRAIN: begin
          if (MEM_REQ) begin
            state        <= REDIR;
            ALT_PC_VALID <= 1'b1;
            ALT_PC       <= MEM_PC;
            pend_pri     <= PRI_MEM;
            FLUSH_FE     <= '1;
            FLUSH_ID     <= 1'b1;
            HOLD_FETCH   <= 1'b0;
          end else if (cnt == 4'd0) begin
            state <= SYSWAIT;
            SYS   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SYSWAIT: begin
          if (MEM_REQ) begin
            state        <= REDIR;
            ALT_PC_VALID <= 1'b1;
            ALT_PC       <= MEM_PC;
            pend_pri     <= PRI_MEM;
            FLUSH_FE     <= '1;
            FLUSH_ID     <= 1'b1;
            HOLD_FETCH   <= 1'b0;
            SYS          <= 1'b0;
          end else if (SYS_ACK) begin
            state        <= REDIR;
            ALT_PC_VALID <= 1'b1;
            ALT_PC       <= sys_pc + 32'd4;
            pend_pri     <= PRI_SYS;
            HOLD_FETCH   <= 1'b0;
            SYS          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed scoreboard bench for fetch_redirect_ctrl.
module tb_fetch_redirect_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PRED_REQ, ID_REQ, MEM_REQ, SYS_REQ, SYS_ACK, STALL;
  logic [31:0] PRED_PC, ID_PC, MEM_PC, SYS_PC;
  logic        ALT_PC_VALID, FLUSH_ID, HOLD_FETCH, SYS, BUSY;
  logic [31:0] ALT_PC;
  logic [6:0]  FLUSH_FE;

  fetch_redirect_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .PRED_REQ(PRED_REQ), .PRED_PC(PRED_PC),
    .ID_REQ(ID_REQ), .ID_PC(ID_PC),
    .MEM_REQ(MEM_REQ), .MEM_PC(MEM_PC),
    .SYS_REQ(SYS_REQ), .SYS_PC(SYS_PC),
    .SYS_ACK(SYS_ACK), .STALL(STALL),
    .ALT_PC_VALID(ALT_PC_VALID), .ALT_PC(ALT_PC),
    .FLUSH_FE(FLUSH_FE), .FLUSH_ID(FLUSH_ID),
    .HOLD_FETCH(HOLD_FETCH), .SYS(SYS), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [43:0] v;
  } exp_t;

  exp_t        sbq[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [43:0] obs;

  assign obs = {ALT_PC_VALID, ALT_PC, FLUSH_FE, FLUSH_ID,
                HOLD_FETCH, SYS, BUSY};

  task automatic push(input string tag, input logic v,
                      input logic [31:0] pc, input logic [6:0] fe,
                      input logic fid, input logic hold,
                      input logic sys, input logic busy);
    exp_t e;
    e.tag = tag;
    e.v   = {v, pc, fe, fid, hold, sys, busy};
    sbq.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sbq.pop_front();
    nvec++;
    assert (obs === e.v) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    check_out();
  endtask

  task automatic idle_chk(input string tag);
    push(tag, 1'b0, 32'h0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic clr();
    PRED_REQ = 1'b0; ID_REQ = 1'b0; MEM_REQ = 1'b0;
    SYS_REQ  = 1'b0; SYS_ACK = 1'b0; STALL = 1'b0;
    PRED_PC  = '0; ID_PC = '0; MEM_PC = '0; SYS_PC = '0;
  endtask

  // Issue a syscall and walk it to SYSWAIT, checking each drain cycle.
  task automatic enter_syswait(input logic [31:0] pc);
    SYS_REQ = 1'b1; SYS_PC = pc;
    push("sys_drain0", 1'b0, 32'h0, 7'h7F, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    SYS_REQ = 1'b0;
    for (int i = 1; i < 3; i++) begin
      push("sys_drain", 1'b0, 32'h0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    push("sys_wait", 1'b0, 32'h0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clr();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    push("reset", 1'b0, 32'h0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    RESET = 1'b0;
    idle_chk("idle_after_reset");

    // ID mispredict
    ID_REQ = 1'b1; ID_PC = 32'h0040_0080;
    push("id_t1", 1'b1, 32'h0040_0080, 7'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clr();
    idle_chk("id_t2");

    // Stalled predictor redirect
    PRED_REQ = 1'b1; PRED_PC = 32'h100; STALL = 1'b1;
    push("pred_s1", 1'b1, 32'h100, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    PRED_REQ = 1'b0;
    push("pred_s2", 1'b1, 32'h100, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    push("pred_s3", 1'b1, 32'h100, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    STALL = 1'b0;
    idle_chk("pred_clear");

    // Simultaneous requests
    MEM_REQ = 1'b1; MEM_PC = 32'h200;
    ID_REQ = 1'b1; ID_PC = 32'h300;
    PRED_REQ = 1'b1; PRED_PC = 32'h400;
    push("simul", 1'b1, 32'h200, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    clr();
    idle_chk("simul_clear");

    // ID overrides a held PRED; a later PRED is ignored
    PRED_REQ = 1'b1; PRED_PC = 32'h400; STALL = 1'b1;
    push("ovr_pred", 1'b1, 32'h400, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    PRED_REQ = 1'b0; ID_REQ = 1'b1; ID_PC = 32'h300;
    push("ovr_id", 1'b1, 32'h300, 7'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    ID_REQ = 1'b0; PRED_REQ = 1'b1; PRED_PC = 32'h999;
    push("ovr_low_ign", 1'b1, 32'h300, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clr();
    idle_chk("ovr_clear");

    // SYS_ACK outside SYSWAIT
    SYS_ACK = 1'b1;
    idle_chk("ack_ignored");
    clr();

    // Syscall with resume at +4; ID ignored while waiting
    enter_syswait(32'h0040_0010);
    ID_REQ = 1'b1; ID_PC = 32'h777;
    push("sys_id_ign", 1'b0, 32'h0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    ID_REQ = 1'b0; SYS_ACK = 1'b1;
    push("sys_resume", 1'b1, 32'h0040_0014, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clr();
    idle_chk("sys_done");

    // PC wraparound
    enter_syswait(32'hFFFF_FFFC);
    SYS_ACK = 1'b1;
    push("sys_wrap", 1'b1, 32'h0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clr();
    idle_chk("wrap_done");

    // MEM aborts a syscall
    enter_syswait(32'h0040_0010);
    MEM_REQ = 1'b1; MEM_PC = 32'h500;
    push("abort", 1'b1, 32'h500, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    clr();
    SYS_ACK = 1'b1;
    idle_chk("abort_no_plus4");
    clr();
    idle_chk("abort_idle");

    // Reset mid-flight during a stalled redirect
    PRED_REQ = 1'b1; PRED_PC = 32'h123; STALL = 1'b1;
    push("rst_pre", 1'b1, 32'h123, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    PRED_REQ = 1'b0;
    RESET = 1'b1;
    #1;
    push("rst_async", 1'b0, 32'h0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    idle_chk("rst_held");
    RESET = 1'b0; STALL = 1'b0;
    idle_chk("rst_idle");

    // Reset during drain: no SYS afterwards
    SYS_REQ = 1'b1; SYS_PC = 32'h0040_0010;
    push("rst_drain0", 1'b0, 32'h0, 7'h7F, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    SYS_REQ = 1'b0;
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) idle_chk("rst_no_sys");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
